// File: rtl/shop_pkg.sv
// Shared ASCII bounds and FSM state encoding for the Caesar-shift decoder path.
package shop_pkg;

    localparam logic [7:0] UC_A      = 8'h41;
    localparam logic [7:0] UC_Z      = 8'h5A;
    localparam logic [7:0] LC_A      = 8'h61;
    localparam logic [7:0] LC_Z      = 8'h7A;
    localparam int         ALPHA_LEN = 26;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/shop_char_dec_v.sv
// Purpose: undo a +k Caesar shift on one ASCII byte; non-letters pass through.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module shop_char_dec_v
    import shop_pkg::*;
#(
    parameter int KEY_W = 3
) (
    input  logic [7:0]       ch,
    input  logic [KEY_W-1:0] k,
    output logic [7:0]       dec
);

    logic       is_uc;
    logic       is_lc;
    logic [7:0] base;
    logic [5:0] off;
    logic [5:0] kk;
    logic [5:0] off_dec;

    always_comb begin
        is_uc = (ch >= UC_A) && (ch <= UC_Z);
        is_lc = (ch >= LC_A) && (ch <= LC_Z);
        base  = is_uc ? UC_A : LC_A;
        off   = 6'(ch - base);
        kk    = 6'(k);
        // Offset stays within 0..25, so a single +26 restores the wrap.
        if (off < kk) begin
            off_dec = off + 6'(ALPHA_LEN) - kk;
        end else begin
            off_dec = off - kk;
        end
        dec = (is_uc || is_lc) ? (base + {2'b00, off_dec}) : ch;
    end

endmodule

// File: rtl/shop_dec_v.sv
// Purpose: receiver-side Caesar decoder, one character per clock, leftmost first.
// Latency: o_valid high CHARS edges after accept; one word per CHARS+2 cycles.
// Backpressure: result held in DONE until i_ready; o_ready low outside IDLE.
module shop_dec_v
    import shop_pkg::*;
#(
    parameter int CHARS = 3,
    parameter int KEY_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               a,
    input  logic               b,
    input  logic               c,
    input  logic [8*CHARS-1:0] i_code,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [8*CHARS-1:0] o_f,
    output logic               o_busy
);

    localparam int W     = 8 * CHARS;
    localparam int IDX_W = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHARS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     work;
    logic [W-1:0]     work_nxt;
    logic [W-1:0]     f_reg;
    logic [KEY_W-1:0] key;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cur_ch;
    logic [7:0]       dec_ch;

    always_comb begin
        cur_ch = '0;
        for (int i = 0; i < CHARS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_ch = work[W-1-8*i -: 8];
            end
        end
    end

    shop_char_dec_v #(.KEY_W(KEY_W)) u_char_dec (
        .ch  (cur_ch),
        .k   (key),
        .dec (dec_ch)
    );

    always_comb begin
        work_nxt = work;
        for (int i = 0; i < CHARS; i++) begin
            if (idx == IDX_W'(i)) begin
                work_nxt[W-1-8*i -: 8] = dec_ch;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_valid)         state_nxt = ST_DECODE;
            ST_DECODE: if (idx == IDX_LAST) state_nxt = ST_DONE;
            ST_DONE:   if (i_ready)         state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    // Key is captured only at acceptance so source-side key changes cannot corrupt a word in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            work  <= '0;
            key   <= '0;
            idx   <= '0;
            f_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        work <= i_code;
                        key  <= KEY_W'({a, b, c});
                        idx  <= '0;
                    end
                end
                ST_DECODE: begin
                    work <= work_nxt;
                    idx  <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        f_reg <= work_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready = (state == ST_IDLE);
    assign o_busy  = (state == ST_DECODE);
    assign o_valid = (state == ST_DONE);
    assign o_f     = f_reg;

endmodule

// File: tb/tb_shop_dec_v.sv
// Bench for shop_dec_v: transaction-level reference model, per-cycle compare, directed and random words.
module tb_shop_dec_v;

    localparam int CHARS = 3;
    localparam int W     = 8 * CHARS;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         a, b, c;
    logic [W-1:0] i_code;
    logic         i_ready;
    logic         o_ready;
    logic         o_valid;
    logic         o_busy;
    logic [W-1:0] o_f;

    int tests = 0;
    int fails = 0;

    shop_dec_v #(.CHARS(CHARS), .KEY_W(3)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .a       (a),
        .b       (b),
        .c       (c),
        .i_code  (i_code),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_f     (o_f),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_ch(input logic [7:0] ch, input int k);
        int v;
        v = int'(ch);
        if (v >= 65 && v <= 90)  return 8'(65 + ((v - 65 - k + 26) % 26));
        if (v >= 97 && v <= 122) return 8'(97 + ((v - 97 - k + 26) % 26));
        return ch;
    endfunction

    function automatic logic [W-1:0] ref_word(input logic [W-1:0] code, input int k);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < CHARS; i++) r[8*i +: 8] = ref_ch(code[8*i +: 8], k);
        return r;
    endfunction

    // Reference model: a word is decoded at accept time and appears CHARS edges later.
    int           m_left;
    bit           m_valid;
    logic [W-1:0] m_f;
    logic [W-1:0] m_pend;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_left  = 0;
            m_valid = 0;
            m_f     = '0;
        end else if (m_valid) begin
            if (i_ready) m_valid = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1;
                m_f     = m_pend;
            end
        end else if (i_valid) begin
            m_pend = ref_word(i_code, int'({a, b, c}));
            m_left = CHARS;
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("cyc_ready", 32'(o_ready), 32'(!m_valid && m_left == 0));
            chk("cyc_busy",  32'(o_busy),  32'(m_left > 0));
            chk("cyc_valid", 32'(o_valid), 32'(m_valid));
            chk("cyc_f",     32'(o_f),     32'(m_f));
        end
    end

    function automatic logic [7:0] rand_byte();
        logic [7:0] edges [8];
        edges = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return 8'(65 + $urandom_range(0, 25));
            4, 5, 6, 7: return 8'(97 + $urandom_range(0, 25));
            8:          return 8'($urandom);
            default:    return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    task automatic wait_valid(input string nm, output int cnt);
        cnt = 0;
        while (!o_valid && cnt < 20) begin
            @(negedge i_clk);
            cnt++;
        end
        if (cnt >= 20) chk({nm, "_timeout"}, 32'(o_valid), 32'd1);
    endtask

    task automatic run_word(input logic [W-1:0] code, input logic [2:0] k, input logic [2:0] k_after,
                            input logic [W-1:0] exp, input string nm);
        int cnt;
        @(negedge i_clk);
        i_valid = 1'b1; i_code = code; {a, b, c} = k; i_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0; {a, b, c} = k_after; i_code = W'($urandom);
        wait_valid(nm, cnt);
        chk({nm, "_lat"}, 32'(cnt), 32'd3);
        chk({nm, "_f"}, 32'(o_f), 32'(exp));
        @(negedge i_clk);
        chk({nm, "_vld_drop"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        logic [W-1:0] held;
        i_rst = 1'b1; i_valid = 1'b0; i_code = '0; {a, b, c} = 3'b000; i_ready = 1'b0;
        #12;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_f",     32'(o_f),     32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        run_word(24'h434241, 3'b111, 3'b111, 24'h565554, "cba_k7");
        run_word(24'h7A6167, 3'b111, 3'b111, 24'h73747A, "zag_k7");
        run_word(24'h206869, 3'b111, 3'b111, 24'h206162, "sp_hi_k7");
        run_word(24'h546573, 3'b000, 3'b000, 24'h546573, "tes_k0");
        run_word(24'h000042, 3'b000, 3'b000, 24'h000042, "nul_k0");
        run_word(24'h434244, 3'b111, 3'b000, 24'h565557, "cbd_keychg");
        run_word(24'h5A7B40, 3'b011, 3'b101, 24'h577B40, "edge_k3");

        // Backpressure: hold result while consumer stalls, reject new words.
        @(negedge i_clk);
        i_ready = 1'b0; i_valid = 1'b1; i_code = 24'h7A6167; {a, b, c} = 3'b111;
        @(negedge i_clk);
        i_valid = 1'b0;
        wait_valid("bp", cnt);
        chk("bp_f", 32'(o_f), 32'h73747A);
        held = o_f;
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_code = W'($urandom); {a, b, c} = 3'($urandom);
            @(negedge i_clk);
            chk("bp_hold_valid", 32'(o_valid), 32'd1);
            chk("bp_hold_f",     32'(o_f),     32'(held));
            chk("bp_hold_ready", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_release_valid", 32'(o_valid), 32'd0);
        chk("bp_release_ready", 32'(o_ready), 32'd1);
        chk("bp_release_f",     32'(o_f),     32'h73747A);

        // Asynchronous reset after one decode cycle.
        @(negedge i_clk);
        i_valid = 1'b1; i_code = 24'h434241; {a, b, c} = 3'b111;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_busy",  32'(o_busy),  32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        chk("arst_f",     32'(o_f),     32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        run_word(24'h434241, 3'b111, 3'b111, 24'h565554, "post_rst");

        // Random traffic: key bits and code wiggle every cycle, consumer stalls randomly.
        for (int n = 0; n < 800; n++) begin
            @(negedge i_clk);
            i_valid = 1'($urandom_range(0, 1));
            i_code  = {rand_byte(), rand_byte(), rand_byte()};
            {a, b, c} = 3'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge i_clk);
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (8) @(negedge i_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
